// File: rtl/rv_wb_pkg.sv
// rtl/rv_wb_pkg.sv - shared types and constants for the two-master Wishbone arbiter
package rv_wb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GNT_M0 = 2'd1,
        S_GNT_M1 = 2'd2
    } arb_state_t;

    // Master index, used for round-robin memory
    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_idx_t;

    // One-hot grant encodings driven on o_grant
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    // Under contention the master that was not granted last wins
    function automatic master_idx_t rr_pick(input master_idx_t last);
        return (last == M0) ? M1 : M0;
    endfunction

endpackage

// File: rtl/rv_wb_timeout.sv
// rtl/rv_wb_timeout.sv - stalled-strobe counter with a single-cycle expiry pulse
//
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_active        arbiter is in a grant state
//   i_stb           granted master's strobe (before any forcing)
//   i_ack, i_err    slave termination
//   o_expired       high in the cycle the stall limit is reached
module rv_wb_timeout
    import rv_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_active,
    input  logic i_stb,
    input  logic i_ack,
    input  logic i_err,
    output logic o_expired
);

    localparam int              CW    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;
    logic          stall;

    assign stall     = i_stb & ~i_ack & ~i_err;
    assign o_expired = i_active & stall & (count == LIMIT);

    always_ff @(posedge i_clk) begin
        if (i_reset || !i_active || i_ack || i_err || o_expired) begin
            count <= '0;
        end else if (i_stb) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/rv_wb_arbiter.sv
// rtl/rv_wb_arbiter.sv - round-robin arbiter for an instruction and a data Wishbone master
//
// Optional feature: define RV_WB_ARB_TIMEOUT_EN to abort stalled cycles after
// TIMEOUT_CYCLES with a one-cycle err to the granted master.
//
// Ports:
//   i_clk, i_reset             clock, synchronous active-high reset
//   i_m0_*, o_m0_*             master 0 (read-only instruction fetch)
//   i_m1_*, o_m1_*             master 1 (data, read/write)
//   o_wb_*, i_wb_*             shared Wishbone bus towards the slave
//   o_grant                    one-hot owner (bit0 = M0, bit1 = M1)
//   o_busy                     mirrors o_wb_cyc
module rv_wb_arbiter
    import rv_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,

    input  logic        i_m0_cyc,
    input  logic        i_m0_stb,
    input  logic [31:0] i_m0_adr,
    output logic [31:0] o_m0_dat,
    output logic        o_m0_ack,
    output logic        o_m0_err,

    input  logic        i_m1_cyc,
    input  logic        i_m1_stb,
    input  logic [31:0] i_m1_adr,
    input  logic [31:0] i_m1_dat,
    input  logic        i_m1_we,
    input  logic [3:0]  i_m1_sel,
    output logic [31:0] o_m1_dat,
    output logic        o_m1_ack,
    output logic        o_m1_err,

    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_we,
    output logic [3:0]  o_wb_sel,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,

    output logic [1:0]  o_grant,
    output logic        o_busy
);

    arb_state_t  state, state_next;
    master_idx_t r_last, last_next;
    logic        tmo_expired;
    logic        gnt_active;
    logic        gnt_stb;

    assign gnt_active = (state != S_IDLE);
    assign gnt_stb    = (state == S_GNT_M0) ? i_m0_stb :
                        (state == S_GNT_M1) ? i_m1_stb : 1'b0;

`ifdef RV_WB_ARB_TIMEOUT_EN
    rv_wb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_active  (gnt_active),
        .i_stb     (gnt_stb),
        .i_ack     (i_wb_ack),
        .i_err     (i_wb_err),
        .o_expired (tmo_expired)
    );
`else
    // No watchdog in this build; the parameter is only referenced so it stays
    // part of the interface without a dangling declaration.
    assign tmo_expired = 1'b0 && (TIMEOUT_CYCLES != 0) && gnt_active && gnt_stb;
`endif

    // Read data fans out to both masters; only ack/err qualify it
    assign o_m0_dat = i_wb_dat;
    assign o_m1_dat = i_wb_dat;
    assign o_busy   = o_wb_cyc;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state  <= S_IDLE;
            r_last <= M0;
        end else begin
            state  <= state_next;
            r_last <= last_next;
        end
    end

    always_comb begin
        state_next = state;
        last_next  = r_last;
        o_wb_cyc   = 1'b0;
        o_wb_stb   = 1'b0;
        o_wb_adr   = '0;
        o_wb_dat   = '0;
        o_wb_we    = 1'b0;
        o_wb_sel   = '0;
        o_grant    = GNT_NONE;
        o_m0_ack   = 1'b0;
        o_m0_err   = 1'b0;
        o_m1_ack   = 1'b0;
        o_m1_err   = 1'b0;

        case (state)
            S_IDLE: begin
                if (i_m0_cyc && i_m1_cyc) begin
                    last_next  = rr_pick(r_last);
                    state_next = (rr_pick(r_last) == M0) ? S_GNT_M0 : S_GNT_M1;
                end else if (i_m0_cyc) begin
                    last_next  = M0;
                    state_next = S_GNT_M0;
                end else if (i_m1_cyc) begin
                    last_next  = M1;
                    state_next = S_GNT_M1;
                end
            end

            S_GNT_M0: begin
                o_wb_cyc = i_m0_cyc & ~tmo_expired;
                o_wb_stb = i_m0_stb & ~tmo_expired;
                o_wb_adr = i_m0_adr;
                o_wb_sel = 4'hF;
                o_grant  = GNT_M0;
                // Ack still forwarded in the cycle the master drops cyc
                o_m0_ack = i_wb_ack;
                o_m0_err = i_wb_err | tmo_expired;
                // No direct handoff: always pass through IDLE between owners
                if (!i_m0_cyc || tmo_expired) begin
                    state_next = S_IDLE;
                end
            end

            S_GNT_M1: begin
                o_wb_cyc = i_m1_cyc & ~tmo_expired;
                o_wb_stb = i_m1_stb & ~tmo_expired;
                o_wb_adr = i_m1_adr;
                o_wb_dat = i_m1_dat;
                o_wb_we  = i_m1_we;
                o_wb_sel = i_m1_sel;
                o_grant  = GNT_M1;
                o_m1_ack = i_wb_ack;
                o_m1_err = i_wb_err | tmo_expired;
                if (!i_m1_cyc || tmo_expired) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rv_wb_arbiter.sv
// tb/tb_rv_wb_arbiter.sv - scoreboard bench for rv_wb_arbiter
module tb_rv_wb_arbiter;

    logic        i_clk;
    logic        i_reset;
    logic        i_m0_cyc, i_m0_stb;
    logic [31:0] i_m0_adr;
    logic [31:0] o_m0_dat;
    logic        o_m0_ack, o_m0_err;
    logic        i_m1_cyc, i_m1_stb;
    logic [31:0] i_m1_adr, i_m1_dat;
    logic        i_m1_we;
    logic [3:0]  i_m1_sel;
    logic [31:0] o_m1_dat;
    logic        o_m1_ack, o_m1_err;
    logic        o_wb_cyc, o_wb_stb;
    logic [31:0] o_wb_adr, o_wb_dat;
    logic        o_wb_we;
    logic [3:0]  o_wb_sel;
    logic [31:0] i_wb_dat;
    logic        i_wb_ack, i_wb_err;
    logic [1:0]  o_grant;
    logic        o_busy;

    rv_wb_arbiter #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_m0_cyc (i_m0_cyc),
        .i_m0_stb (i_m0_stb),
        .i_m0_adr (i_m0_adr),
        .o_m0_dat (o_m0_dat),
        .o_m0_ack (o_m0_ack),
        .o_m0_err (o_m0_err),
        .i_m1_cyc (i_m1_cyc),
        .i_m1_stb (i_m1_stb),
        .i_m1_adr (i_m1_adr),
        .i_m1_dat (i_m1_dat),
        .i_m1_we  (i_m1_we),
        .i_m1_sel (i_m1_sel),
        .o_m1_dat (o_m1_dat),
        .o_m1_ack (o_m1_ack),
        .o_m1_err (o_m1_err),
        .o_wb_cyc (o_wb_cyc),
        .o_wb_stb (o_wb_stb),
        .o_wb_adr (o_wb_adr),
        .o_wb_dat (o_wb_dat),
        .o_wb_we  (o_wb_we),
        .o_wb_sel (o_wb_sel),
        .i_wb_dat (i_wb_dat),
        .i_wb_ack (i_wb_ack),
        .i_wb_err (i_wb_err),
        .o_grant  (o_grant),
        .o_busy   (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        m;
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_m0(input logic cyc, input logic stb, input logic [31:0] adr);
        i_m0_cyc = cyc;
        i_m0_stb = stb;
        i_m0_adr = adr;
    endtask

    task automatic set_m1(input logic cyc, input logic stb, input logic [31:0] adr,
                          input logic [31:0] dat, input logic we, input logic [3:0] sel);
        i_m1_cyc = cyc;
        i_m1_stb = stb;
        i_m1_adr = adr;
        i_m1_dat = dat;
        i_m1_we  = we;
        i_m1_sel = sel;
    endtask

    // Master 0 transfers always appear as reads with full byte lanes
    task automatic push_m0(input logic [31:0] adr, input logic [31:0] rdata);
        exp_t e;
        e.m = 1'b0; e.adr = adr; e.dat = 32'h0; e.we = 1'b0; e.sel = 4'hF; e.rdata = rdata;
        sb_q.push_back(e);
    endtask

    task automatic push_m1(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                           input logic [3:0] sel, input logic [31:0] rdata);
        exp_t e;
        e.m = 1'b1; e.adr = adr; e.dat = dat; e.we = we; e.sel = sel; e.rdata = rdata;
        sb_q.push_back(e);
    endtask

    // Every ack delivered to a master must match the oldest expected transfer
    always @(negedge i_clk) begin
        if (o_m0_ack || o_m1_ack) begin
            if (sb_q.size() == 0) begin
                check("sb_spurious_ack", {62'h0, o_m1_ack, o_m0_ack}, 64'h0);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_ack_route", {62'h0, o_m1_ack, o_m0_ack}, mon_e.m ? 64'h2 : 64'h1);
                check("sb_grant", {62'h0, o_grant}, mon_e.m ? 64'h2 : 64'h1);
                check("sb_adr", {32'h0, o_wb_adr}, {32'h0, mon_e.adr});
                check("sb_wdat", {32'h0, o_wb_dat}, {32'h0, mon_e.dat});
                check("sb_we", {63'h0, o_wb_we}, {63'h0, mon_e.we});
                check("sb_sel", {60'h0, o_wb_sel}, {60'h0, mon_e.sel});
                check("sb_rdata", {32'h0, (mon_e.m ? o_m1_dat : o_m0_dat)}, {32'h0, mon_e.rdata});
            end
        end
    end

    int errs;
    int first_err;
    int cyc_cnt;
    int n_loop;
    logic [1:0] g16;

    initial begin
        i_reset  = 1'b1;
        set_m0(1'b0, 1'b0, 32'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        i_wb_dat = 32'h0;
        i_wb_ack = 1'b0;
        i_wb_err = 1'b0;

        // Reset state: idle bus, ack/err blocked, read data still passes
        nc();
        nc();
        i_wb_ack = 1'b1;
        i_wb_err = 1'b1;
        i_wb_dat = 32'h1234_5678;
        #2;
        check("rst_cyc", {63'h0, o_wb_cyc}, 64'h0);
        check("rst_grant", {62'h0, o_grant}, 64'h0);
        check("rst_busy", {63'h0, o_busy}, 64'h0);
        check("rst_ack_err", {60'h0, o_m1_ack, o_m0_ack, o_m1_err, o_m0_err}, 64'h0);
        check("rst_dat", {o_m1_dat, o_m0_dat}, 64'h1234_5678_1234_5678);
        nc();
        i_reset  = 1'b0;
        i_wb_ack = 1'b0;
        i_wb_err = 1'b0;
        #2;
        check("rst_idle_bus", {o_wb_adr, 24'h0, o_wb_sel, 3'h0, o_wb_we}, 64'h0);

        // Single m0 read, two wait states
        set_m0(1'b1, 1'b1, 32'h100);
        #2;
        check("t1_pre_grant_cyc", {63'h0, o_wb_cyc}, 64'h0);
        nc();
        #2;
        check("t1_cyc", {63'h0, o_wb_cyc}, 64'h1);
        check("t1_adr", {32'h0, o_wb_adr}, 64'h100);
        check("t1_sel", {60'h0, o_wb_sel}, 64'hF);
        check("t1_grant", {62'h0, o_grant}, 64'h1);
        check("t1_busy", {63'h0, o_busy}, 64'h1);
        nc();
        #2;
        check("t1_wait_ack", {63'h0, o_m0_ack}, 64'h0);
        nc();
        nc();
        push_m0(32'h100, 32'hCAFE_0001);
        i_wb_ack = 1'b1;
        i_wb_dat = 32'hCAFE_0001;
        #2;
        check("t1_m0_ack", {63'h0, o_m0_ack}, 64'h1);
        check("t1_m1_ack", {63'h0, o_m1_ack}, 64'h0);
        nc();
        i_wb_ack = 1'b0;
        set_m0(1'b0, 1'b0, 32'h0);
        #2;
        check("t1_release_cyc", {63'h0, o_wb_cyc}, 64'h0);
        nc();

        // Contention right after reset: m1 first, then m0 after one idle cycle
        i_reset = 1'b1;
        nc();
        i_reset = 1'b0;
        set_m0(1'b1, 1'b1, 32'h200);
        set_m1(1'b1, 1'b1, 32'h300, 32'h0, 1'b0, 4'hF);
        nc();
        #2;
        check("t2_first_grant", {62'h0, o_grant}, 64'h2);
        push_m1(32'h300, 32'h0, 1'b0, 4'hF, 32'hBEEF_0002);
        i_wb_ack = 1'b1;
        i_wb_dat = 32'hBEEF_0002;
        nc();
        i_wb_ack = 1'b0;
        set_m1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        #2;
        check("t2_m0_wait_grant", {62'h0, o_grant}, 64'h2);
        nc();
        #2;
        check("t2_turnaround", {62'h0, o_grant}, 64'h0);
        nc();
        #2;
        check("t2_second_grant", {62'h0, o_grant}, 64'h1);
        push_m0(32'h200, 32'hBEEF_0003);
        i_wb_ack = 1'b1;
        i_wb_dat = 32'hBEEF_0003;
        nc();
        i_wb_ack = 1'b0;
        set_m0(1'b0, 1'b0, 32'h0);
        nc();

        // m1 write passes through exactly; err routed to m1 only
        set_m1(1'b1, 1'b1, 32'h2000_0004, 32'hDEAD_BEEF, 1'b1, 4'b1100);
        nc();
        #2;
        check("t3_grant", {62'h0, o_grant}, 64'h2);
        check("t3_adr", {32'h0, o_wb_adr}, 64'h2000_0004);
        check("t3_dat", {32'h0, o_wb_dat}, 64'hDEAD_BEEF);
        check("t3_sel_we", {59'h0, o_wb_sel, o_wb_we}, {59'h0, 4'b1100, 1'b1});
        nc();
        i_wb_err = 1'b1;
        #2;
        check("t3_wait_ack", {63'h0, o_m1_ack}, 64'h0);
        check("t3_err_route", {62'h0, o_m1_err, o_m0_err}, 64'h2);
        nc();
        i_wb_err = 1'b0;
        push_m1(32'h2000_0004, 32'hDEAD_BEEF, 1'b1, 4'b1100, 32'h0);
        i_wb_ack = 1'b1;
        i_wb_dat = 32'h0;
        #2;
        check("t3_ack", {63'h0, o_m1_ack}, 64'h1);
        nc();
        i_wb_ack = 1'b0;
        #2;
        check("t3_ack_low", {63'h0, o_m1_ack}, 64'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        nc();

        // m0 locks the bus for three transfers while m1 waits
        set_m0(1'b1, 1'b1, 32'h400);
        nc();
        #2;
        check("t4_grant", {62'h0, o_grant}, 64'h1);
        set_m1(1'b1, 1'b1, 32'h500, 32'h0, 1'b0, 4'hF);
        for (int i = 0; i < 3; i++) begin
            nc();
            i_m0_adr = 32'h400 + 32'(i * 4);
            push_m0(32'h400 + 32'(i * 4), 32'hA0 + 32'(i));
            i_wb_ack = 1'b1;
            i_wb_dat = 32'hA0 + 32'(i);
            if (i == 2) begin
                i_m0_cyc = 1'b0;
            end
            #2;
            check("t4_hold_grant", {62'h0, o_grant}, 64'h1);
            nc();
            i_wb_ack = 1'b0;
            #2;
            if (i < 2) begin
                check("t4_hold_gap", {62'h0, o_grant}, 64'h1);
            end else begin
                check("t4_turnaround", {62'h0, o_grant}, 64'h0);
                i_m0_stb = 1'b0;
            end
        end
        nc();
        #2;
        check("t4_m1_grant", {62'h0, o_grant}, 64'h2);
        push_m1(32'h500, 32'h0, 1'b0, 4'hF, 32'h5555_AAAA);
        i_wb_ack = 1'b1;
        i_wb_dat = 32'h5555_AAAA;
        nc();
        i_wb_ack = 1'b0;
        set_m1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        nc();

        // Reset during an m1 cycle; a late ack must not reach m1
        set_m1(1'b1, 1'b1, 32'h600, 32'h11, 1'b1, 4'h3);
        nc();
        #2;
        check("t5_grant", {62'h0, o_grant}, 64'h2);
        i_reset = 1'b1;
        nc();
        i_reset  = 1'b0;
        i_wb_ack = 1'b1;
        #2;
        check("t5_cyc", {63'h0, o_wb_cyc}, 64'h0);
        check("t5_m1_ack", {63'h0, o_m1_ack}, 64'h0);
        check("t5_grant_none", {62'h0, o_grant}, 64'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        nc();
        i_wb_ack = 1'b0;
        nc();
        nc();

        // Stalled slave: watchdog err, or indefinite hold without it
        set_m0(1'b1, 1'b1, 32'h700);
        nc();
        errs      = 0;
        first_err = -1;
        cyc_cnt   = 0;
        g16       = 2'b11;
`ifdef RV_WB_ARB_TIMEOUT_EN
        n_loop = 20;
`else
        n_loop = 110;
`endif
        for (int k = 0; k < n_loop; k++) begin
            #2;
            if (o_m0_err) begin
                errs++;
                if (first_err < 0) begin
                    first_err = k;
                end
            end
            if (o_wb_cyc && o_grant == 2'b01) begin
                cyc_cnt++;
            end
            if (k == 16) begin
                g16 = o_grant;
            end
            nc();
        end
`ifdef RV_WB_ARB_TIMEOUT_EN
        check("t6_err_count", 64'(errs), 64'd1);
        check("t6_err_cycle", 64'(first_err), 64'd15);
        check("t6_idle_after", {62'h0, g16}, 64'h0);
`else
        check("t6_err_count", 64'(errs), 64'd0);
        check("t6_hold_cycles", 64'(cyc_cnt), 64'd110);
        check("t6_grant_k16", {62'h0, g16}, 64'h1);
`endif
        set_m0(1'b0, 1'b0, 32'h0);
        nc();
        nc();

        check("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rv_wb_arbiter.md
RV_WB_ARBITER -- requirements
Module: rv_wb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: stalled-cycle limit; used only with RV_WB_ARB_TIMEOUT_EN.
REQ-002 SHALL have one clock and a synchronous active-high reset: i_clk  in  1  clock; i_reset  in  1  reset, sampled on the i_clk rising edge.
REQ-003 Master 0 (instruction, read-only) ports SHALL be:
- i_m0_cyc  in  1
- i_m0_stb  in  1
- i_m0_adr  in  32
- o_m0_dat  out  32
- o_m0_ack  out  1
- o_m0_err  out  1
REQ-004 Master 1 (data) ports SHALL be:
- i_m1_cyc  in  1
- i_m1_stb  in  1
- i_m1_adr  in  32
- i_m1_dat  in  32
- i_m1_we  in  1
- i_m1_sel  in  4
- o_m1_dat  out  32
- o_m1_ack  out  1
- o_m1_err  out  1
REQ-005 Shared Wishbone bus ports SHALL be:
- o_wb_cyc  out  1
- o_wb_stb  out  1
- o_wb_adr  out  32
- o_wb_dat  out  32
- o_wb_we  out  1
- o_wb_sel  out  4
- i_wb_dat  in  32
- i_wb_ack  in  1
- i_wb_err  in  1
REQ-006 Status ports SHALL be: o_grant  out  2  one-hot owner (bit0=M0, bit1=M1); o_busy  out  1  = o_wb_cyc.

Function
REQ-007 FSM states SHALL be IDLE, GNT_M0 and GNT_M1, held in a registered state.
REQ-008 All bus-side outputs SHALL be combinational from the state register and the granted master's inputs, never from the non-granted master.
REQ-009 In IDLE, all of o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel and o_grant SHALL be 0.
REQ-010 IDLE transitions SHALL be:
- only i_m0_cyc -> GNT_M0
- only i_m1_cyc -> GNT_M1
- both -> the master not granted last (round robin via r_last)
REQ-011 r_last SHALL update on every grant and SHALL reset to M0, so the first contention after reset grants M1.
REQ-012 Grant latency SHALL be one cycle: cyc seen in IDLE at edge N gives o_wb_cyc=1 in the cycle after edge N.
REQ-013 In GNT_Mx: o_wb_cyc SHALL equal i_mx_cyc and o_wb_stb SHALL equal i_mx_stb.
REQ-014 In GNT_M0, o_wb_adr SHALL be i_m0_adr, o_wb_we 0, o_wb_sel 4'hF and o_wb_dat 0; in GNT_M1 these SHALL pass through from master 1.
REQ-015 i_wb_ack and i_wb_err SHALL route combinationally, in the same cycle, to the granted master only; the non-granted master's ack and err SHALL be 0.
REQ-016 o_m0_dat and o_m1_dat SHALL both equal i_wb_dat unconditionally.
REQ-017 Grant SHALL be held while the granted master keeps cyc high (bus lock), including across multiple stb/ack transfers.
REQ-018 The FSM SHALL return to IDLE on the edge where the granted i_mx_cyc is 0; no direct handoff, so one idle turnaround cycle is required between owners.
REQ-019 An ack arriving in the same cycle the granted master drops cyc SHALL still be forwarded to that master.
REQ-020 A master requesting while the other holds the bus SHALL wait and SHALL receive no ack or err.

Reset
REQ-021 On an i_reset edge the FSM SHALL go to IDLE, r_last to M0 and the timeout counter to 0.
REQ-022 All outputs except o_m*_dat SHALL be 0 in the following cycle.
REQ-023 Reset asserted mid-transfer SHALL abort the cycle with no ack or err delivered after the reset edge.

Configuration
REQ-024 With RV_WB_ARB_TIMEOUT_EN defined:
- counter increments each cycle with o_wb_stb=1 and i_wb_ack=0 and i_wb_err=0
- clears on ack, err, or leaving GNT
- on reaching TIMEOUT_CYCLES-1: one-cycle err to the granted master, o_wb_cyc/stb forced 0 that cycle, FSM to IDLE
REQ-025 Without RV_WB_ARB_TIMEOUT_EN, no counter SHALL exist, err SHALL be pure i_wb_err pass-through, and a stalled slave SHALL hang the bus indefinitely.

Structure
REQ-026 Package rv_wb_pkg SHALL hold the state enum typedef, the grant one-hot constants (GNT_NONE, GNT_M0, GNT_M1) and the master-index type.
REQ-027 Sub-module rv_wb_timeout (counter plus expiry pulse) SHALL be instantiated only under RV_WB_ARB_TIMEOUT_EN.

Verification
REQ-028 Only m0 cyc/stb, adr 0x100, ack after 2 wait cycles -> o_wb_cyc in cycle 1, o_wb_adr=0x100, o_wb_sel=F, o_m0_ack in the cycle of i_wb_ack, o_m1_ack=0.
REQ-029 m0 and m1 raise cyc in the same cycle after reset -> o_grant=2'b10 first; after m1 drops cyc, one IDLE cycle, then o_grant=2'b01.
REQ-030 m1 write adr 0x2000_0004, dat 0xDEADBEEF, sel 4'b1100, we=1 -> bus carries exact values; o_m1_ack mirrors i_wb_ack.
REQ-031 m0 holds cyc across 3 ack'd transfers while m1 requests -> m0 keeps grant for all 3; m1 granted 2 cycles after m0 drops cyc.
REQ-032 i_reset pulsed while GNT_M1 with stb high, ack arriving the cycle after -> o_wb_cyc=0 after the edge; o_m1_ack stays 0.
REQ-033 With macro, TIMEOUT_CYCLES=16, no ack -> o_m0_err=1 for exactly 1 cycle 15 cycles after stb rises, then IDLE; without macro, bus stays granted for 100+ cycles.
